// File: rtl/stable_capture_ctrl.sv
// Qualifies the synchronized input bus: a value must hold for STABLE_CYCLES enabled cycles,
// then it is captured once and offered downstream through a valid/ready handshake.
module stable_capture_ctrl #(
    parameter int WIDTH         = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [WIDTH-1:0] data_sync,
    input  logic             out_ready,
    input  logic             overrun_clr,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    output logic             overrun
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

    typedef enum logic {
        IDLE  = 1'b0,
        VALID = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] ref_q;
    logic [CW-1:0]    cnt;
    logic             stable;
    logic             new_val;
    logic             overrun_set;

    // A qualified value only counts as an event when it differs from what was last delivered.
    assign stable      = (cnt == CNT_MAX);
    assign new_val     = stable && (ref_q != data_out);
    assign overrun_set = (state == VALID) && !out_ready && new_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_q     <= '0;
            cnt       <= '0;
            state     <= IDLE;
            data_out  <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (ena) begin
            if (data_sync != ref_q) begin
                ref_q <= data_sync;
                cnt   <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (new_val) begin
                        data_out  <= ref_q;
                        out_valid <= 1'b1;
                        state     <= VALID;
                    end
                end
                VALID: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase

            // Setting wins over a simultaneous clear.
            if (overrun_set) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule
